// File: rtl/vga_frame_streamer.sv
// 640x480@60 VGA timing with a timing-locked RAM fetch for a centred 256x256 grayscale window.
// Outputs lag counter position by RD_LAT+2 clocks; free-running, no backpressure (RAM port b is read every clock).
module vga_frame_streamer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int X_OFF    = 192,
    parameter int Y_OFF    = 112,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        VGA_enable,
    input  logic [7:0]  pixel,
    output logic [15:0] pixelAddress,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int DLY   = RD_LAT + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_E  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_BEG    = HW'(X_OFF);
    localparam logic [HW-1:0] X_END    = HW'(X_OFF + IMG_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_BEG    = VW'(Y_OFF);
    localparam logic [VW-1:0] Y_END    = VW'(Y_OFF + IMG_H);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic img;
        logic en;
        logic org;
    } tim_t;

    // Idle stage keeps syncs deasserted so a reset never produces a short sync pulse.
    localparam tim_t TIM_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, img: 1'b0, en: 1'b0, org: 1'b0};

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          frame_en_q, frame_en_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   next_addr_q, next_addr_d;
    tim_t          dly_q [DLY];
    tim_t          dly_d [DLY];
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic [7:0]    pix_q, pix_d;
    logic          fs_q, fs_d;

    tim_t raw;
    tim_t out;
    logic h_wrap;
    logic at_origin;

    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end

        frame_en_d = at_origin ? VGA_enable : frame_en_q;

        raw.hs  = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
        raw.vs  = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
        raw.act = (h_cnt_q < H_ACT_E) && (v_cnt_q < V_ACT_E);
        raw.img = (h_cnt_q >= X_BEG) && (h_cnt_q < X_END) &&
                  (v_cnt_q >= Y_BEG) && (v_cnt_q < Y_END);
        raw.en  = frame_en_q;
        raw.org = at_origin;

        // Raster order inside the window makes a running index equal (v-Y_OFF)*IMG_W+(h-X_OFF).
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        if (at_origin) begin
            addr_d      = '0;
            next_addr_d = '0;
        end else if (raw.img && frame_en_q) begin
            addr_d      = next_addr_q;
            next_addr_d = next_addr_q + 16'd1;
        end

        dly_d[0] = raw;
        for (int i = 1; i < DLY; i++) begin
            dly_d[i] = dly_q[i-1];
        end

        out     = dly_q[DLY-1];
        hsync_d = out.hs;
        vsync_d = out.vs;
        blank_d = out.act;
        pix_d   = (out.img && out.en && out.act) ? pixel : 8'd0;
        fs_d    = out.org;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_en_q  <= 1'b0;
            addr_q      <= '0;
            next_addr_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                dly_q[i] <= TIM_IDLE;
            end
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            blank_q     <= 1'b0;
            pix_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_en_q  <= frame_en_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            for (int i = 0; i < DLY; i++) begin
                dly_q[i] <= dly_d[i];
            end
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
            pix_q       <= pix_d;
            fs_q        <= fs_d;
        end
    end

    assign pixelAddress = addr_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blank_n      = blank_q;
    assign r            = pix_q;
    assign g            = pix_q;
    assign b            = pix_q;
    assign frame_start  = fs_q;

endmodule

// File: tb/tb_vga_frame_streamer.sv
// Bench for vga_frame_streamer: a full-size instance for 640x480 line timing and a reduced-geometry
// instance so whole frames, enable boundaries and a mid-frame reset fit in a short run.
module tb_vga_frame_streamer;
    // Reduced geometry: 48-clock lines, 31-line frames (1488 clocks), 16x8 image at (8,5).
    localparam int SH_ACT = 32, SH_FP = 4, SH_SYNC = 6, SH_BP = 6;
    localparam int SV_ACT = 24, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
    localparam int S_IMG_W = 16, S_IMG_H = 8, S_X = 8, S_Y = 5;

    localparam int S_HS = 0, S_VS = 1, S_BLK = 2, S_R = 3, S_G = 4, S_B = 5, S_ADDR = 6, S_FS = 7;
    localparam int F_HS = 8, F_BLK = 9, F_ADDR = 10, F_R = 11, F_FS = 12;

    localparam int R  = 5;          // last reset edge before the first release
    localparam int R2 = R + 6453;   // the single-clock mid-frame reset edge

    typedef struct {
        int    cyc;
        int    sel;
        int    exp;
        string name;
    } chk_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic vga_en = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    chk_t sb[$];

    logic [7:0]  pix_s, pix_f;
    logic [15:0] pa_s, pa_f;
    logic        hs_s, vs_s, blk_s, fs_s;
    logic        hs_f, vs_f, blk_f, fs_f;
    logic [7:0]  r_s, g_s, b_s, r_f, g_f, b_f;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency RAM models returning addr[7:0]^addr[15:8].
    always @(posedge clk) pix_s <= pa_s[7:0] ^ pa_s[15:8];
    always @(posedge clk) pix_f <= pa_f[7:0] ^ pa_f[15:8];

    vga_frame_streamer #(
        .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
        .IMG_W(S_IMG_W), .IMG_H(S_IMG_H), .X_OFF(S_X), .Y_OFF(S_Y), .RD_LAT(1)
    ) u_small (
        .clk(clk), .reset(reset), .VGA_enable(vga_en), .pixel(pix_s),
        .pixelAddress(pa_s), .hsync(hs_s), .vsync(vs_s), .blank_n(blk_s),
        .r(r_s), .g(g_s), .b(b_s), .frame_start(fs_s)
    );

    vga_frame_streamer u_full (
        .clk(clk), .reset(reset), .VGA_enable(vga_en), .pixel(pix_f),
        .pixelAddress(pa_f), .hsync(hs_f), .vsync(vs_f), .blank_n(blk_f),
        .r(r_f), .g(g_f), .b(b_f), .frame_start(fs_f)
    );

    function automatic int sample(input int sel);
        case (sel)
            S_HS:    return int'(hs_s);
            S_VS:    return int'(vs_s);
            S_BLK:   return int'(blk_s);
            S_R:     return int'(r_s);
            S_G:     return int'(g_s);
            S_B:     return int'(b_s);
            S_ADDR:  return int'(pa_s);
            S_FS:    return int'(fs_s);
            F_HS:    return int'(hs_f);
            F_BLK:   return int'(blk_f);
            F_ADDR:  return int'(pa_f);
            F_R:     return int'(r_f);
            F_FS:    return int'(fs_f);
            default: return -1;
        endcase
    endfunction

    // Insert keeping the scoreboard ordered by due cycle.
    task automatic ex(input int c, input int sel, input int v, input string nm);
        chk_t e;
        int   i;
        e.cyc = c; e.sel = sel; e.exp = v; e.name = nm;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    // Screen position p (clocks since (0,0)): address visible at R+p+1, outputs at R+p+3.
    task automatic ex_addr(input int base, input int p, input int v, input string nm);
        ex(base + p + 1, S_ADDR, v, nm);
    endtask

    task automatic ex_out(input int base, input int p, input int sel, input int v, input string nm);
        ex(base + p + 3, sel, v, nm);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        chk_t e;
        int   act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            act = sample(e.sel);
            n_run++;
            if (e.cyc != cyc || act != e.exp) begin
                n_fail++;
                $display("FAIL %s @cyc %0d (due %0d): got %0d, expected %0d", e.name, cyc, e.cyc, act, e.exp);
            end
        end
    end

    initial begin
        chk_t e;
        // Reset values on both instances.
        ex(R, S_HS, 1, "rst_hs");    ex(R, S_VS, 1, "rst_vs");   ex(R, S_BLK, 0, "rst_blank");
        ex(R, S_R, 0, "rst_r");      ex(R, S_ADDR, 0, "rst_addr"); ex(R, S_FS, 0, "rst_fs");
        ex(R, F_HS, 1, "rst_full_hs"); ex(R, F_BLK, 0, "rst_full_blank");
        ex(R, F_ADDR, 0, "rst_full_addr"); ex(R, F_R, 0, "rst_full_r");
        ex(R + 1, S_HS, 1, "rel_hs_1"); ex(R + 2, S_HS, 1, "rel_hs_2");
        ex(R + 1, F_HS, 1, "rel_full_hs_1"); ex(R + 2, F_HS, 1, "rel_full_hs_2");
        ex(R + 3, S_FS, 1, "fs_first"); ex(R + 3, F_FS, 1, "fs_full_first"); ex(R + 4, S_FS, 0, "fs_one_cycle");

        // Full-size hsync: falls 659 clocks after release, low 96, period 800; 640 active clocks.
        ex(R + 658, F_HS, 1, "full_hs_before"); ex(R + 659, F_HS, 0, "full_hs_fall");
        ex(R + 754, F_HS, 0, "full_hs_last_low"); ex(R + 755, F_HS, 1, "full_hs_rise");
        ex(R + 1458, F_HS, 1, "full_hs2_before"); ex(R + 1459, F_HS, 0, "full_hs2_fall");
        ex(R + 642, F_BLK, 1, "full_blank_h639"); ex(R + 643, F_BLK, 0, "full_blank_h640");

        // Reduced geometry timing: hsync h=36..41, vsync v=26..27, active h<32, v<24.
        ex_out(R, 35, S_HS, 1, "hs_h35");  ex_out(R, 36, S_HS, 0, "hs_h36");
        ex_out(R, 41, S_HS, 0, "hs_h41");  ex_out(R, 42, S_HS, 1, "hs_h42");
        ex_out(R, 83, S_HS, 1, "hs_l1_h35"); ex_out(R, 84, S_HS, 0, "hs_l1_h36");
        ex_out(R, 1247, S_VS, 1, "vs_v25"); ex_out(R, 1248, S_VS, 0, "vs_v26");
        ex_out(R, 1343, S_VS, 0, "vs_v27_end"); ex_out(R, 1344, S_VS, 1, "vs_v28");
        ex_out(R, 31, S_BLK, 1, "blank_h31"); ex_out(R, 32, S_BLK, 0, "blank_h32");
        ex_out(R, 1135, S_BLK, 1, "blank_v23"); ex_out(R, 1152, S_BLK, 0, "blank_v24");
        ex_out(R, 1487, S_FS, 0, "fs_f2_before"); ex_out(R, 1488, S_FS, 1, "fs_f2");

        // Frame 1 address sequence.
        ex_addr(R, 247, 0, "addr_pre_img");  ex_addr(R, 248, 0, "addr_first");
        ex_addr(R, 249, 1, "addr_second");   ex_addr(R, 263, 15, "addr_row0_end");
        ex_addr(R, 264, 15, "addr_row0_hold"); ex_addr(R, 296, 16, "addr_row1_start");
        ex_addr(R, 599, 127, "addr_last");   ex_addr(R, 1487, 127, "addr_hold_eof");
        ex_addr(R, 1488, 0, "addr_frame_clear");

        // Frame 1 data: r at image (k,j) = 16*j+k; black outside the window.
        ex_out(R, 249, S_R, 1, "r_k1_j0");    ex_out(R, 263, S_R, 15, "r_k15_j0");
        ex_out(R, 296, S_R, 16, "r_k0_j1");   ex_out(R, 349, S_R, 37, "r_k5_j2");
        ex_out(R, 349, S_G, 37, "g_k5_j2");   ex_out(R, 349, S_B, 37, "b_k5_j2");
        ex_out(R, 599, S_R, 127, "r_last");
        ex_out(R, 264, S_R, 0, "r_right_black"); ex_out(R, 264, S_BLK, 1, "blank_right_of_img");
        ex_out(R, 295, S_R, 0, "r_left_black");  ex_out(R, 295, S_BLK, 1, "blank_left_of_img");

        // Enable dropped mid frame 2: frame 2 intact, frame 3 black with address 0, frame 4 resumes.
        ex_out(R, 1981, S_R, 85, "f2_r_after_drop"); ex_addr(R, 2087, 127, "f2_addr_last");
        ex_addr(R, 3464, 0, "f3_addr_after_raise"); ex_addr(R, 3575, 0, "f3_addr_off");
        ex_out(R, 3469, S_R, 0, "f3_r_off");   ex_out(R, 3469, S_BLK, 1, "f3_blank");
        ex_addr(R, 4760, 16, "f4_addr_resume"); ex_out(R, 4813, S_R, 37, "f4_r_resume");

        // Mid-frame reset at (20,10) of frame 5.
        ex(R + 6452, S_R, 89, "pre_rst_r"); ex(R + 6452, S_ADDR, 91, "pre_rst_addr");
        ex(R2, S_HS, 1, "mid_rst_hs"); ex(R2, S_VS, 1, "mid_rst_vs"); ex(R2, S_BLK, 0, "mid_rst_blank");
        ex(R2, S_R, 0, "mid_rst_r");   ex(R2, S_ADDR, 0, "mid_rst_addr"); ex(R2, S_FS, 0, "mid_rst_fs");
        ex(R2 + 1, S_HS, 1, "post_rst_hs_1"); ex(R2 + 2, S_HS, 1, "post_rst_hs_2");
        ex(R2 + 3, S_FS, 1, "post_rst_fs");
        ex_out(R2, 35, S_HS, 1, "post_hs_h35"); ex_out(R2, 36, S_HS, 0, "post_hs_h36");
        ex_out(R2, 41, S_HS, 0, "post_hs_h41"); ex_out(R2, 42, S_HS, 1, "post_hs_h42");
        ex_addr(R2, 296, 16, "post_addr_row1"); ex_out(R2, 349, S_R, 37, "post_r_k5_j2");

        wait_cyc(R);
        n_run++;
        if (hs_s !== 1'b1 || vs_s !== 1'b1 || blk_s !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_rst_sync_small: hs=%0b vs=%0b blank_n=%0b", hs_s, vs_s, blk_s);
        end
        n_run++;
        if (r_s !== 8'd0 || g_s !== 8'd0 || b_s !== 8'd0 || pa_s !== 16'd0) begin
            n_fail++;
            $display("FAIL direct_rst_data_small: r=%0d g=%0d b=%0d addr=%0d", r_s, g_s, b_s, pa_s);
        end
        n_run++;
        if (hs_f !== 1'b1 || vs_f !== 1'b1 || blk_f !== 1'b0 || pa_f !== 16'd0) begin
            n_fail++;
            $display("FAIL direct_rst_full: hs=%0b vs=%0b blank_n=%0b addr=%0d", hs_f, vs_f, blk_f, pa_f);
        end
        reset = 1'b1;
        wait_cyc(R + 1872);
        vga_en = 1'b0;
        wait_cyc(R + 3360);
        vga_en = 1'b1;
        wait_cyc(R + 6452);
        reset = 1'b0;
        wait_cyc(R2);
        n_run++;
        if (hs_s !== 1'b1 || vs_s !== 1'b1 || blk_s !== 1'b0 || fs_s !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_mid_rst_sync: hs=%0b vs=%0b blank_n=%0b fs=%0b", hs_s, vs_s, blk_s, fs_s);
        end
        n_run++;
        if (r_s !== 8'd0 || pa_s !== 16'd0) begin
            n_fail++;
            $display("FAIL direct_mid_rst_data: r=%0d addr=%0d", r_s, pa_s);
        end
        reset = 1'b1;
        wait_cyc(R2 + 400);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_run++;
            n_fail++;
            $display("FAIL %s: never sampled, due cyc %0d, expected %0d", e.name, e.cyc, e.exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_frame_streamer.md
Name: vga_frame_streamer

Overview:
- Display back-end downstream of the CPU's dual-port pixel RAM.
- Generates 640x480@60 VGA timing and drives the RAM read-port address (port b) to fetch one 8-bit pixel per clock for a 256x256 image window.
- Realigns sync and blank to the RAM read latency and outputs grayscale RGB to the DAC.
- Replaces the free-running pixel-address counter with a timing-locked one.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- IMG_W, 256, image width in pixels
- IMG_H, 256, image height in lines
- X_OFF, 192, image left edge, screen x
- Y_OFF, 112, image top edge, screen y
- RD_LAT, 1, RAM port-b read latency in clocks

Ports:
- clk  in  1  pixel clock (25.175 MHz); only clock
- reset  in  1  synchronous, active-low reset
- VGA_enable  in  1  display enable switch
- pixel  in  8  RAM port-b read data
- pixelAddress  out  16  RAM port-b read address
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank_n  out  1  high inside 640x480 active area
- r, g, b  out  8 each  colour outputs
- frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Reset: when reset==0 at a clk edge:
  - h_cnt=0, v_cnt=0, pixelAddress=0.
  - hsync=1, vsync=1, blank_n=0, r=g=b=0, frame_start=0.
  - All delay-line stages cleared; frame_en=0.
- Counters:
  - h_cnt counts 0..799 and wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..524, and wraps to 0.
  - Line period is 800 clocks; frame period is 420000 clocks.
- Raw timing at counter position (h,v):
  - hsync_raw=0 for 656<=h<=751.
  - vsync_raw=0 for 490<=v<=491.
  - active_raw = (h<640)&&(v<480).
  - in_img = (X_OFF<=h<X_OFF+IMG_W)&&(Y_OFF<=v<Y_OFF+IMG_H).
- Enable:
  - frame_en is loaded from VGA_enable only at (h,v)=(0,0), so VGA_enable changes take effect at the next frame boundary (no tearing).
- Address generation:
  - pixelAddress is registered.
  - At a clk edge where counters are at (h,v) with in_img && frame_en, pixelAddress takes the linear index (v-Y_OFF)*IMG_W+(h-X_OFF).
  - Implemented as an incrementing 16-bit counter cleared at (0,0); no multiplier.
  - Outside the window the address holds its last value.
  - Wraps 65535 -> 0 only via the frame clear.
  - When frame_en==0, the address is held at 0.
- Alignment:
  - Total latency from counter position to outputs is PIPE = RD_LAT+2 clocks (address register + RAM + output register).
  - hsync_raw, vsync_raw, active_raw, in_img and frame_en are delayed through a PIPE-1 stage shift register, then registered with the colour data.
- Outputs:
  - hsync, vsync and blank_n are the delayed raw signals.
  - If the delayed in_img && frame_en && active: r=g=b=pixel. Otherwise r=g=b=0.
  - Black is also output during blanking.
- frame_start pulses one cycle when the delayed position is (0,0), i.e. PIPE clocks after counters reach (0,0).
- Reset asserted mid-frame:
  - Takes effect at that edge; all state returns to reset values.
  - The first frame after release starts at (0,0) with frame_en=0 until the next (0,0) sample.

Test Plan:
- Reset: hold reset=0 for 5 clocks -> hsync=1, vsync=1, blank_n=0, rgb=0, pixelAddress=0. Release, then count edges: hsync falls exactly 656+3 clocks after release, stays low 96 clocks, period 800.
- Frame timing: run 2 frames -> vsync low for 1600 clocks (2 lines) per frame; frame_start pulses every 420000 clocks; blank_n high 640 clocks per line on 480 lines only.
- Address sequence: VGA_enable=1 before (0,0). In the enabled frame:
  - first address 0 issued for counter (192,112);
  - 255 at (447,112);
  - 256 at (192,113);
  - 65535 at (447,367);
  - held 65535 until the next frame clears it.
- Data alignment: RAM model with 1-cycle latency returning pixel=addr[7:0]^addr[15:8] -> r at screen (192+k,112+j) equals k^j; (191,112) and (448,112) output black with blank_n=1.
- Enable boundary: drop VGA_enable mid-frame at v=200 -> image continues to the end of the frame; next frame rgb=0 throughout with pixelAddress=0; raise it mid-frame -> image resumes only at the following frame.
- Mid-operation reset: assert reset=0 for 1 clock at (h,v)=(300,250) -> next cycle all outputs at reset values, counters restart at 0, no hsync glitch shorter than 96 clocks afterwards.
